// File: rtl/mac_pkg.sv
// Shared definitions for the mac_col front-end: column instruction codes,
// issuer FSM states and default vector geometry.
package mac_pkg;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  localparam int DEF_BW = 8;
  localparam int DEF_PR = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    GAP   = 3'd2,
    EXEC  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } issuer_state_e;

endpackage

// File: rtl/mac_issue_cnt.sv
// Loadable up-counter that stops at its terminal value; reports a match now
// (hit) and a match after one more increment (hit_next).
module mac_issue_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         hit,
  output logic         hit_next
);

  assign hit      = (cnt == term);
  assign hit_next = ((W+1)'(cnt) + (W+1)'(1)) == (W+1)'(term);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !hit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mac_inst_issuer.sv
// Load/execute sequencer driving column 0 of the mac_col chain.
// Optional MAC_ISSUER_PERF_EN adds exec/stall cycle counters.
module mac_inst_issuer
  import mac_pkg::*;
#(
  parameter int bw    = DEF_BW,
  parameter int pr    = DEF_PR,
  parameter int col   = 8,
  parameter int nq_bw = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [nq_bw-1:0]    num_query,
  input  logic [pr*bw-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [1:0]          o_inst,
  output logic [pr*bw-1:0]    q_out,
  input  logic                fifo_wr_in,
  output logic                busy,
  output logic                done,
`ifdef MAC_ISSUER_PERF_EN
  output logic [31:0]         exec_cycles,
  output logic [31:0]         stall_cycles,
`endif
  output issuer_state_e       state_dbg,
  output logic [((($clog2(col+1)) > nq_bw) ? $clog2(col+1) : nq_bw)-1:0] beat_cnt_dbg,
  output logic [nq_bw-1:0]    res_cnt_dbg
);

  // One beat counter serves both phases, so it is wide enough for col and num_query.
  localparam int CW  = (($clog2(col+1)) > nq_bw) ? $clog2(col+1) : nq_bw;
  localparam logic [CW-1:0] COL_TERM = CW'(col);

  // Handshake: a beat is in_valid & in_ready; in_data is consumed only on a beat.
  issuer_state_e    state;
  logic [nq_bw-1:0] nq_r;
  logic [pr*bw-1:0] q_stage;
  logic             beat, start_acc, res_inc;
  logic [CW-1:0]    beat_term;
  logic             beat_hit, beat_last, res_hit, res_last;

  assign start_acc = start && (state == IDLE);
  assign res_inc   = fifo_wr_in && (state != IDLE);
  assign beat_term = (state == EXEC) ? CW'(nq_r) : COL_TERM;
  assign in_ready  = ((state == LOAD) || (state == EXEC)) && !beat_hit;
  assign beat      = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  mac_issue_cnt #(.W(CW)) u_beat_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (start_acc || (state == GAP)),
    .inc      (beat),
    .term     (beat_term),
    .cnt      (beat_cnt_dbg),
    .hit      (beat_hit),
    .hit_next (beat_last)
  );

  mac_issue_cnt #(.W(nq_bw)) u_res_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (start_acc),
    .inc      (res_inc),
    .term     (nq_r),
    .cnt      (res_cnt_dbg),
    .hit      (res_hit),
    .hit_next (res_last)
  );

  // q_out trails o_inst by one cycle: the column registers i_inst before sampling q_in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      nq_r    <= '0;
      o_inst  <= INST_IDLE;
      q_stage <= '0;
      q_out   <= '0;
    end else begin
      o_inst  <= INST_IDLE;
      q_stage <= '0;
      q_out   <= q_stage;
      if (beat) begin
        o_inst  <= (state == LOAD) ? INST_LOAD : INST_EXEC;
        q_stage <= in_data;
      end
      case (state)
        IDLE:  if (start) begin
                 state <= LOAD;
                 nq_r  <= num_query;
               end
        LOAD:  if (beat && beat_last) state <= GAP;
        GAP:   state <= (nq_r == '0) ? DRAIN : EXEC;
        EXEC:  if (beat && beat_last) state <= DRAIN;
        DRAIN: if (res_hit || (res_inc && res_last)) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAC_ISSUER_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exec_cycles  <= '0;
      stall_cycles <= '0;
    end else if (start_acc) begin
      exec_cycles  <= '0;
      stall_cycles <= '0;
    end else begin
      if ((state == EXEC) && (exec_cycles != '1)) exec_cycles <= exec_cycles + 1'b1;
      if (((state == LOAD) || (state == EXEC)) && !beat && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule
